// File: rtl/cnnip_mem_arbiter.sv
// rtl/cnnip_mem_arbiter.sv - round-robin arbiter for the shared CNN-IP memory port with in-order read tag FIFO
// Optional grant lock enabled by defining CNNIP_ARB_LOCK_EN.
module cnnip_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUT    = 4,
  localparam int WEW       = ((DATA_WIDTH - 1) >> 3) + 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_en,
  input  logic [NUM_REQ*WEW-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_din,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             req_gnt,
  output logic [DATA_WIDTH-1:0]          rsp_dout,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           mem_en,
  output logic [WEW-1:0]                 mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_din,
  input  logic [DATA_WIDTH-1:0]          mem_dout,
  input  logic                           mem_valid,
  output logic                           err_unexp_valid
);

  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]      CNT_MAX  = CW'(MAX_OUT);
  localparam logic [TW-1:0]      LAST_RST = TW'(NUM_REQ - 1);
  localparam logic [TW:0]        NUM_W    = (TW+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  logic [TW-1:0]      last_gnt;
  logic [TW-1:0]      sel;
  logic               found;
  logic               acc;
  logic               push;
  logic               pop;
  logic               not_full;
  logic               lock_active;
  logic [NUM_REQ-1:0] is_rd;
  logic [NUM_REQ-1:0] elig;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [TW-1:0]      tag_mem [MAX_OUT];

  // Full check uses the registered count only; a same-cycle pop does not free a slot.
  assign not_full = (cnt < CNT_MAX);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      is_rd[i] = (req_we[i*WEW +: WEW] == '0);
      elig[i]  = req_en[i] & (~is_rd[i] | not_full);
    end
  end

`ifdef CNNIP_ARB_LOCK_EN
  logic lock_vld;

  assign lock_active = lock_vld & req_en[last_gnt] & req_lock[last_gnt];

  // Lock stays armed while the holder is blocked so nobody else slips in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_vld <= 1'b0;
    end else begin
      lock_vld <= acc | lock_active;
    end
  end
`else
  logic unused_lock;

  assign lock_active = 1'b0;
  assign unused_lock = ^req_lock;
`endif

  always_comb begin
    logic [TW:0] sum;
    found = 1'b0;
    sel   = last_gnt;
    sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_gnt} + (TW+1)'(k);
      if (sum >= NUM_W) begin
        sum = sum - NUM_W;
      end
      if (!found && elig[sum[TW-1:0]]) begin
        found = 1'b1;
        sel   = sum[TW-1:0];
      end
    end
    if (lock_active) begin
      found = elig[last_gnt];
      sel   = last_gnt;
    end
    req_gnt = found ? (ONE << sel) : '0;
  end

  assign acc  = found;
  assign push = acc & is_rd[sel];
  assign pop  = mem_valid & (cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_en   <= 1'b0;
      mem_we   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      last_gnt <= LAST_RST;
    end else if (acc) begin
      mem_en   <= 1'b1;
      mem_we   <= req_we[sel*WEW +: WEW];
      mem_addr <= req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
      mem_din  <= req_din[sel*DATA_WIDTH +: DATA_WIDTH];
      last_gnt <= sel;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_unexp_valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (mem_valid && (cnt == '0)) begin
        err_unexp_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= sel;
    end
  end

  assign rsp_valid = pop ? (ONE << tag_mem[rd_ptr]) : '0;
  assign rsp_dout  = mem_dout;

endmodule

// File: tb/tb_cnnip_mem_arbiter.sv
// tb/tb_cnnip_mem_arbiter.sv - scoreboard bench for cnnip_mem_arbiter with a latency-configurable memory model
module tb_cnnip_mem_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int WEW = 4;

  logic              clk;
  logic              rstn;
  logic [NR-1:0]     req_en;
  logic [NR*WEW-1:0] req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_din;
  logic [NR-1:0]     req_lock;
  logic [NR-1:0]     req_gnt;
  logic [DW-1:0]     rsp_dout;
  logic [NR-1:0]     rsp_valid;
  logic              mem_en;
  logic [WEW-1:0]    mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [DW-1:0]     mem_dout;
  logic              mem_valid;
  logic              err_unexp_valid;

  cnnip_mem_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rstn(rstn), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .req_lock(req_lock), .req_gnt(req_gnt), .rsp_dout(rsp_dout),
    .rsp_valid(rsp_valid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_valid(mem_valid),
    .err_unexp_valid(err_unexp_valid)
  );

  typedef struct { int req; logic [DW-1:0] data; int gcyc; } exp_t;
  typedef struct { int due; logic [DW-1:0] data; } pend_t;

  exp_t          exp_q[$];
  pend_t         pend[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            lat = 2;
  int            exp_last = 0;
  logic          force_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {12'hC0D, a};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [WEW-1:0] w);
    for (int b = 0; b < WEW; b++) if (w[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  // Memory: read data appears lat cycles after the cycle mem_en is high
  always @(posedge clk) begin
    logic [DW-1:0] old;
    pend_t p;
    cyc = cyc + 1;
    if (!rstn) begin
      pend.delete();
      mem_valid <= 1'b0;
      mem_dout  <= '0;
    end else begin
      if (mem_en === 1'b1) begin
        old = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
        if (mem_we != '0) mem_arr[mem_addr] = merge(old, mem_din, mem_we);
        else pend.push_back('{cyc - 1 + lat, old});
      end
      mem_valid <= 1'b0;
      if (force_valid) begin
        mem_valid <= 1'b1;
        mem_dout  <= 32'hBAD0BAD0;
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        mem_valid <= 1'b1;
        mem_dout  <= p.data;
      end
    end
  end

  // Scoreboard: push on observed read grant, pop on rsp_valid
  always @(negedge clk) begin
    exp_t e;
    int g;
    logic [WEW-1:0] w;
    logic [AW-1:0] a;
    logic [DW-1:0] old;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (rsp_valid !== '0) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=%b required 0000", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          if (rsp_valid !== (NR'(1) << e.req) || rsp_dout !== e.data || cyc - e.gcyc != 1 + lat) begin
            n_fail++;
            $display("FAIL rsp_check: valid=%b dout=%h lat=%0d required valid=%b dout=%h lat=%0d",
                     rsp_valid, rsp_dout, cyc - e.gcyc, NR'(1) << e.req, e.data, 1 + lat);
          end
        end
      end
      g = -1;
      for (int i = NR - 1; i >= 0; i--) if (req_gnt[i] === 1'b1) g = i;
      if (g >= 0) begin
        w = req_we[g*WEW +: WEW];
        a = req_addr[g*AW +: AW];
        old = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        if (w == '0) exp_q.push_back('{g, old, cyc});
        else ref_mem[a] = merge(old, req_din[g*DW +: DW], w);
      end
    end
  end

  task automatic drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d reads outstanding required 0", nm, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_en = '0; req_we = '0; req_addr = '0; req_din = '0; req_lock = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({mem_en, mem_we, mem_addr, mem_din, rsp_valid, req_gnt, err_unexp_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b we=%h addr=%h din=%h rv=%b gnt=%b err=%b required all 0",
               mem_en, mem_we, mem_addr, mem_din, rsp_valid, req_gnt, err_unexp_valid);
    end
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({mem_en, mem_we, mem_addr, mem_din, rsp_valid, req_gnt, err_unexp_valid} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: en=%b gnt=%b rv=%b err=%b required all 0",
               mem_en, req_gnt, rsp_valid, err_unexp_valid);
    end
    @(posedge clk); #1;
    req_en = 4'hF;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(i * 'h100 + 'h40);
    @(negedge clk);
    n_chk++;
    if (req_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant: gnt=%b required 0001", req_gnt);
    end
    @(posedge clk); #1 req_en = '0;
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 20'h00040 || mem_we !== '0) begin
      n_fail++;
      $display("FAIL first_issue: en=%b addr=%h we=%h required 1 00040 0", mem_en, mem_addr, mem_we);
    end
    drain("reset");
    exp_last = 0;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ra [NR];
    int e;
    lat = 2;
    for (int i = 0; i < NR; i++) ra[i] = AW'('h1000 + i * 'h40);
    e = (exp_last + 1) % NR;
    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      req_en = 4'hF;
      req_we = '0;
      for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = ra[i];
      @(negedge clk);
      n_chk++;
      if (req_gnt !== (NR'(1) << e) || mem_en !== (t > 0)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: gnt=%b mem_en=%b required %b %b", t, req_gnt, mem_en,
                 NR'(1) << e, t > 0);
      end
      ra[e] = ra[e] + 1'b1;
      exp_last = e;
      e = (e + 1) % NR;
    end
    @(posedge clk); #1 idle_inputs();
    drain("rr");
  endtask

  task automatic test_full_stall();
    int exp_g [9] = '{2, 2, 2, 2, 0, 4, 0, 0, 2};
    logic [AW-1:0] a1 = 20'h00300;
    lat = 6;
    for (int t = 0; t < 9; t++) begin
      @(posedge clk); #1;
      req_en = (t == 5) ? 4'b0110 : 4'b0010;
      req_we = 16'h0F00;
      req_addr[1*AW +: AW] = a1;
      req_addr[2*AW +: AW] = 20'h00200;
      req_din[2*DW +: DW]  = 32'h12345678;
      @(negedge clk);
      n_chk++;
      if (req_gnt !== NR'(exp_g[t])) begin
        n_fail++;
        $display("FAIL stall_gnt[%0d]: gnt=%b required %b", t, req_gnt, NR'(exp_g[t]));
      end
      if (t == 6) begin
        n_chk++;
        if (mem_en !== 1'b1 || mem_we !== 4'hF || mem_addr !== 20'h00200 || mem_din !== 32'h12345678) begin
          n_fail++;
          $display("FAIL stall_write_issue: en=%b we=%h addr=%h din=%h required 1 f 00200 12345678",
                   mem_en, mem_we, mem_addr, mem_din);
        end
      end
      if (req_gnt[1] === 1'b1) a1 = a1 + 1'b1;
    end
    @(posedge clk); #1 idle_inputs();
    drain("stall");
    exp_last = 1;
  endtask

  task automatic test_mixed();
    bit got = 0;
    lat = 2;
    @(posedge clk); #1;
    req_en = 4'b0001;
    req_we = 16'h000F;
    req_addr[0 +: AW] = 20'h00010;
    req_din[0 +: DW]  = 32'hDEADBEEF;
    @(negedge clk);
    n_chk++;
    if (req_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mixed_write_gnt: gnt=%b required 0001", req_gnt);
    end
    @(posedge clk); #1;
    req_en = 4'b1000;
    req_we = '0;
    req_addr[3*AW +: AW] = 20'h00010;
    @(negedge clk);
    n_chk++;
    if (req_gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL mixed_read_gnt: gnt=%b required 1000", req_gnt);
    end
    @(posedge clk); #1 idle_inputs();
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        got = 1;
        n_chk++;
        if (rsp_valid !== 4'b1000 || rsp_dout !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL mixed_rsp: valid=%b dout=%h required 1000 deadbeef", rsp_valid, rsp_dout);
        end
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL mixed_rsp_timeout: no rsp_valid within 10 cycles");
    end
    drain("mixed");
  endtask

  task automatic test_unexpected();
    @(posedge clk); #1 force_valid = 1'b1;
    @(posedge clk); #1 force_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (mem_valid !== 1'b1 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL unexp_rsp_valid: mem_valid=%b rsp_valid=%b required 1 0000", mem_valid, rsp_valid);
    end
    @(negedge clk);
    n_chk++;
    if (err_unexp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL unexp_err_set: err=%b required 1", err_unexp_valid);
    end
    repeat (5) @(negedge clk);
    n_chk++;
    if (err_unexp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL unexp_err_sticky: err=%b required 1", err_unexp_valid);
    end
  endtask

  task automatic test_err_clear();
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    n_chk++;
    if (err_unexp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b required 0", err_unexp_valid);
    end
    @(posedge clk); #1 rstn = 1'b1;
    exp_last = NR - 1;
  endtask

  task automatic test_lock();
`ifdef CNNIP_ARB_LOCK_EN
    int exp_g [7] = '{4, 4, 4, 4, 4, 1, 2};
`else
    int exp_g [7] = '{4, 1, 2, 4, 1, 2, 1};
`endif
    for (int t = 0; t < 7; t++) begin
      @(posedge clk); #1;
      req_en   = (t == 0) ? 4'b0100 : (t < 5) ? 4'b0111 : 4'b0011;
      req_lock = (t < 5) ? 4'b0100 : 4'b0000;
      req_we   = 16'hFFFF;
      for (int i = 0; i < NR; i++) begin
        req_addr[i*AW +: AW] = AW'('h500 + i);
        req_din[i*DW +: DW]  = DW'(t * 16 + i);
      end
      @(negedge clk);
      n_chk++;
      if (req_gnt !== NR'(exp_g[t])) begin
        n_fail++;
        $display("FAIL lock_gnt[%0d]: gnt=%b required %b", t, req_gnt, NR'(exp_g[t]));
      end
    end
    @(posedge clk); #1 idle_inputs();
    drain("lock");
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_full_stall();
    test_mixed();
    test_unexpected();
    test_err_clear();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
